// File: rtl/dac_i2s_tx_pkg.sv
// Shared constants and helpers for the mono-to-stereo I2S DAC transmitter.
// Sample words are offset-binary on input and two's complement on the I2S line.
package dac_i2s_tx_pkg;

  localparam int I2S_SLOT_W     = 16;
  localparam int I2S_FRAME_BITS = 2 * I2S_SLOT_W;

  localparam logic [I2S_SLOT_W-1:0] I2S_MIDSCALE = 16'h8000;

  // Offset-binary to two's complement is just an MSB flip.
  function automatic logic [I2S_SLOT_W-1:0] ob_to_tc(input logic [I2S_SLOT_W-1:0] s);
    return {~s[I2S_SLOT_W-1], s[I2S_SLOT_W-2:0]};
  endfunction

endpackage

// File: rtl/dac_i2s_tx_clk_gen.sv
// BCLK / LRCLK generator: divides i_clk into the bit clock and tracks the slot
// position inside the stereo frame. o_fall strobes in the cycle BCLK falls.
module i2s_clk_gen #(
  parameter int BCLK_DIV = 4,
  parameter int SAMPLE_W = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  output logic                          o_bclk,
  output logic                          o_lrclk,
  output logic                          o_fall,
  output logic [$clog2(2*SAMPLE_W)-1:0] o_bit_cnt
);

  localparam int FRAME = 2 * SAMPLE_W;
  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int BIT_W = $clog2(FRAME);

  logic [DIV_W-1:0] r_div_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             r_bclk;
  logic             r_lrclk;

  logic             w_wrap;
  logic             w_fall;
  logic [BIT_W-1:0] w_bit_nxt;

  assign w_wrap    = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
  assign w_fall    = w_wrap & r_bclk;
  assign w_bit_nxt = (r_bit_cnt == BIT_W'(FRAME - 1)) ? '0 : r_bit_cnt + BIT_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
      r_bit_cnt <= BIT_W'(FRAME - 1);
      r_lrclk   <= 1'b1;
    end else begin
      if (w_wrap) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
      // Slot position and word select move only on BCLK falling edges.
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrclk   <= (w_bit_nxt >= BIT_W'(SAMPLE_W));
      end
    end
  end

  assign o_bclk    = r_bclk;
  assign o_lrclk   = r_lrclk;
  assign o_fall    = w_fall;
  assign o_bit_cnt = r_bit_cnt;

endmodule

// File: rtl/dac_i2s_tx.sv
// Mono sample to stereo I2S serialiser with a one-deep hold buffer, per-frame
// sample request and sticky underrun flag. SAMPLE_W is tied to the package slot width.
module dac_i2s_tx
  import dac_i2s_tx_pkg::*;
#(
  parameter int BCLK_DIV = 4,
  parameter int SAMPLE_W = I2S_SLOT_W
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_sample_valid,
  output logic                o_sample_req,
  output logic                o_bclk,
  output logic                o_lrclk,
  output logic                o_sdata,
  output logic                o_underrun
);

  localparam int FRAME = 2 * SAMPLE_W;
  localparam int BIT_W = $clog2(FRAME);

  logic             w_fall;
  logic [BIT_W-1:0] w_bit_cnt;
  logic             w_left_ld;
  logic             w_right_ld;
  logic [SAMPLE_W-1:0] w_src;
  logic [SAMPLE_W-1:0] w_src_tc;

  logic [SAMPLE_W-1:0] r_hold;
  logic                r_fresh;
  logic [SAMPLE_W-1:0] r_shreg;
  logic [SAMPLE_W-1:0] r_word;
  logic                r_sdata;
  logic                r_req;
  logic                r_underrun;

  i2s_clk_gen #(
    .BCLK_DIV (BCLK_DIV),
    .SAMPLE_W (SAMPLE_W)
  ) u_clk_gen (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .o_bclk    (o_bclk),
    .o_lrclk   (o_lrclk),
    .o_fall    (w_fall),
    .o_bit_cnt (w_bit_cnt)
  );

  // bit_cnt is the pre-increment value, so the slot about to start is one ahead.
  assign w_left_ld  = w_fall && (w_bit_cnt == BIT_W'(FRAME - 1));
  assign w_right_ld = w_fall && (w_bit_cnt == BIT_W'(SAMPLE_W - 1));
  assign w_src      = i_sample_valid ? i_sample : r_hold;
  assign w_src_tc   = ob_to_tc(w_src);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_hold     <= I2S_MIDSCALE;
      r_fresh    <= 1'b0;
      r_shreg    <= '0;
      r_word     <= '0;
      r_sdata    <= 1'b0;
      r_req      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_req <= w_left_ld;
      if (i_sample_valid) begin
        r_hold <= i_sample;
      end
      // A valid coinciding with the left load is consumed at once, so fresh ends low.
      if (w_left_ld) begin
        r_fresh <= 1'b0;
        r_word  <= w_src_tc;
        if (!r_fresh && !i_sample_valid) begin
          r_underrun <= 1'b1;
        end
      end else if (i_sample_valid) begin
        r_fresh <= 1'b1;
      end
      // The bit leaving the register lags the load by one slot: standard I2S delay.
      if (w_fall) begin
        r_sdata <= r_shreg[SAMPLE_W-1];
        if (w_left_ld) begin
          r_shreg <= w_src_tc;
        end else if (w_right_ld) begin
          r_shreg <= r_word;
        end else begin
          r_shreg <= {r_shreg[SAMPLE_W-2:0], 1'b0};
        end
      end
    end
  end

  assign o_sample_req = r_req;
  assign o_sdata      = r_sdata;
  assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_dac_i2s_tx.sv
// Directed bench for dac_i2s_tx: decodes I2S frames slot by slot and compares
// against hand-computed words.
module tb_dac_i2s_tx;

  localparam int BCLK_DIV = 4;
  localparam int SAMPLE_W = 16;
  localparam int SLOT_CLK = 2 * BCLK_DIV;
  localparam int FRAME_CLK = SLOT_CLK * 2 * SAMPLE_W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sample;
  logic        valid;
  logic        req, bclk, lrclk, sdata, underrun;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dac_i2s_tx #(.BCLK_DIV(BCLK_DIV), .SAMPLE_W(SAMPLE_W)) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_sample       (sample),
    .i_sample_valid (valid),
    .o_sample_req   (req),
    .o_bclk         (bclk),
    .o_lrclk        (lrclk),
    .o_sdata        (sdata),
    .o_underrun     (underrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_valid(input logic [15:0] d);
    sample = d;
    valid  = 1'b1;
    tick();
    valid  = 1'b0;
  endtask

  task automatic wait_req(input int bound, output int n);
    n = 0;
    while (req !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check("req_timeout", {31'd0, req}, 32'd1);
  endtask

  // Starts in the cycle right after a left-start edge, ends at the next one.
  task automatic run_frame(input int off0, input logic [15:0] d0,
                           input int off1, input logic [15:0] d1,
                           output logic [15:0] l, output logic [15:0] r,
                           output int nmid, output logic req_end);
    logic [32:0] s;
    s    = '0;
    nmid = 0;
    for (int c = 0; c <= FRAME_CLK; c++) begin
      if (c % SLOT_CLK == 0) s[c / SLOT_CLK] = sdata;
      if (c == 0)              check("lrclk_slot0",  {31'd0, lrclk}, 32'd0);
      if (c == 15 * SLOT_CLK)  check("lrclk_slot15", {31'd0, lrclk}, 32'd0);
      if (c == 16 * SLOT_CLK)  check("lrclk_slot16", {31'd0, lrclk}, 32'd1);
      if (c == FRAME_CLK) break;
      if (c > 0 && req === 1'b1) nmid++;
      if (c == off0) begin sample = d0; valid = 1'b1; end
      if (c == off1) begin sample = d1; valid = 1'b1; end
      tick();
      valid = 1'b0;
    end
    req_end = req;
    for (int i = 0; i < 16; i++) begin
      l[15-i] = s[1+i];
      r[15-i] = s[17+i];
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] l, input logic [15:0] r,
                             input int nmid, input logic req_end, input logic [15:0] exp);
    check({tag, "_left"},  {16'd0, l}, {16'd0, exp});
    check({tag, "_right"}, {16'd0, r}, {16'd0, exp});
    check({tag, "_req_mid"}, nmid, 32'd0);
    check({tag, "_req_end"}, {31'd0, req_end}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] l, r, v;
    int          n, nmid;
    logic        req_end;

    rst_n  = 1'b0;
    valid  = 1'b0;
    sample = '0;
    tick();
    tick();
    check("rst_bclk",     {31'd0, bclk},     32'd0);
    check("rst_lrclk",    {31'd0, lrclk},    32'd1);
    check("rst_sdata",    {31'd0, sdata},    32'd0);
    check("rst_req",      {31'd0, req},      32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);

    // No samples at all: first fall on the 8th edge, midscale goes out as zeros.
    rst_n = 1'b1;
    wait_req(40, n);
    check("first_fall_lat", n, 32'd8);
    check("first_bclk",     {31'd0, bclk},     32'd0);
    check("first_lrclk",    {31'd0, lrclk},    32'd0);
    check("first_underrun", {31'd0, underrun}, 32'd1);
    run_frame(-1, 16'h0, -1, 16'h0, l, r, nmid, req_end);
    check_frame("idle", l, r, nmid, req_end, 16'h0000);

    // 0xC000 ahead of the request, then two valids in one frame, then a load-cycle valid.
    do_reset();
    pulse_valid(16'hC000);
    wait_req(40, n);
    check("c000_lat", n, 32'd7);
    check("c000_underrun0", {31'd0, underrun}, 32'd0);
    run_frame(10, 16'h0000, 100, 16'hFFFF, l, r, nmid, req_end);
    check_frame("c000", l, r, nmid, req_end, 16'h4000);
    check("latest_underrun0", {31'd0, underrun}, 32'd0);
    run_frame(FRAME_CLK - 1, 16'h1234, -1, 16'h0, l, r, nmid, req_end);
    check_frame("latest", l, r, nmid, req_end, 16'h7FFF);
    check("ldcyc_underrun0", {31'd0, underrun}, 32'd0);
    run_frame(-1, 16'h0, -1, 16'h0, l, r, nmid, req_end);
    check_frame("ldcyc", l, r, nmid, req_end, 16'h9234);
    check("repeat_underrun1", {31'd0, underrun}, 32'd1);
    run_frame(-1, 16'h0, -1, 16'h0, l, r, nmid, req_end);
    check_frame("repeat", l, r, nmid, req_end, 16'h9234);

    // Ramp: each request answered immediately with the next value.
    do_reset();
    pulse_valid(16'd7);
    wait_req(40, n);
    check("ramp_lat", n, 32'd7);
    for (int f = 0; f < 100; f++) begin
      v = 16'(f * 331 + 7);
      run_frame(0, 16'((f + 1) * 331 + 7), -1, 16'h0, l, r, nmid, req_end);
      check_frame("ramp", l, r, nmid, req_end, v ^ 16'h8000);
      check("ramp_underrun", {31'd0, underrun}, 32'd0);
    end

    // Reset in the middle of right-channel slot 20.
    for (int c = 0; c < 20 * SLOT_CLK + BCLK_DIV; c++) tick();
    check("mid_lrclk_pre", {31'd0, lrclk}, 32'd1);
    check("mid_bclk_pre",  {31'd0, bclk},  32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_bclk",     {31'd0, bclk},     32'd0);
    check("mid_lrclk",    {31'd0, lrclk},    32'd1);
    check("mid_sdata",    {31'd0, sdata},    32'd0);
    check("mid_req",      {31'd0, req},      32'd0);
    check("mid_underrun", {31'd0, underrun}, 32'd0);
    tick();
    rst_n = 1'b1;
    pulse_valid(16'hABCD);
    wait_req(40, n);
    check("restart_lat", n, 32'd7);
    check("restart_lrclk", {31'd0, lrclk}, 32'd0);
    run_frame(-1, 16'h0, -1, 16'h0, l, r, nmid, req_end);
    check_frame("restart", l, r, nmid, req_end, 16'h2BCD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
